whirlpool_wcipher_round_ctrl: RTL

Round sequencer for the Whirlpool W-cipher. It owns the 512-bit key and state registers and runs the R-round schedule. A single external round-function datapath (gamma, pi, then theta) is time-shared between the key-schedule path and the state path. Each round takes two cycles: key phase, then state phase. The block sits between the hash engine's chaining/message registers and the shared round-function datapath.

---
 rtl/whirlpool_wcipher_round_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/whirlpool_wcipher_round_ctrl.sv
// Whirlpool W-cipher round sequencer: owns K/S, shares one gamma/pi/theta datapath, two cycles per round.
// Optional macro ROUND_FEEDFORWARD_EN adds Miyaguchi-Preneel feed-forward (blk_out = E_K(m) ^ m ^ K).
`timescale 1ns/1ps
module whirlpool_wcipher_round_ctrl #(
  parameter int R = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] key_in,
  input  logic [511:0] blk_in,
  output logic [511:0] rf_in,
  input  logic [511:0] rf_out,
  output logic         rf_sel,
  output logic [3:0]   rc_idx,
  input  logic [63:0]  rc,
  output logic         busy,
  output logic         done,
  output logic [511:0] blk_out
);

  typedef enum logic [1:0] {IDLE, KEY, STATE, DONE} state_t;

  state_t       st;
  logic [511:0] k_q;
  logic [511:0] s_q;
  logic [3:0]   rnd;
  logic [511:0] s_nxt;
  logic [511:0] res;

`ifdef ROUND_FEEDFORWARD_EN
  logic [511:0] ff_q;
`endif

  // Only K and S ever reach the shared datapath; it sees zero while idle.
  always_comb begin
    rf_in = '0;
    case (st)
      KEY:     rf_in = k_q;
      STATE:   rf_in = s_q;
      default: rf_in = '0;
    endcase
  end

  assign s_nxt = rf_out ^ k_q;

`ifdef ROUND_FEEDFORWARD_EN
  assign res = s_nxt ^ ff_q;
`else
  assign res = s_nxt;
`endif

  // blk_out is loaded on the last STATE edge so it changes together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      rnd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rf_sel  <= 1'b0;
      rc_idx  <= '0;
      blk_out <= '0;
`ifdef ROUND_FEEDFORWARD_EN
      ff_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            k_q    <= key_in;
            s_q    <= blk_in ^ key_in;
            rnd    <= 4'd1;
            rc_idx <= 4'd1;
            busy   <= 1'b1;
            rf_sel <= 1'b0;
            st     <= KEY;
`ifdef ROUND_FEEDFORWARD_EN
            ff_q   <= key_in ^ blk_in;
`endif
          end
        end
        KEY: begin
          k_q    <= rf_out ^ {rc, 448'h0};
          rf_sel <= 1'b1;
          st     <= STATE;
        end
        STATE: begin
          s_q    <= s_nxt;
          rf_sel <= 1'b0;
          if (rnd == 4'(R)) begin
            blk_out <= res;
            done    <= 1'b1;
            busy    <= 1'b0;
            st      <= DONE;
          end else begin
            rnd    <= rnd + 4'd1;
            rc_idx <= rnd + 4'd1;
            st     <= KEY;
          end
        end
        DONE: begin
          rc_idx <= '0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
